issue_pipe_reg: RTL and testbench
=================================

Name: issue_pipe_reg

Overview:
- Parametrised successor to the fixed dual-issue ID->REG pipeline register.
- Holds one issue bundle of LANES lanes, each lane carrying a PAYLOAD_W packed payload (opcode, register numbers, immediates, forward data and selects).
- Adds a valid/ready handshake with a 2-entry skid buffer, a per-lane kill mask, a bundle-wide flush, an occupancy output and a saturating stall counter.
- Sits between decode/issue and register fetch; instantiated once per pipeline boundary.

Parameters:
- LANES, 2, issue width (number of lanes per bundle); >=1
- PAYLOAD_W, 480, bits per lane payload; >=1
- STALL_CNT_W, 16, width of stall cycle counter

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  upstream bundle valid
- in_lane_en  input  LANES  per-lane valid mask of incoming bundle
- in_payload  input  LANES*PAYLOAD_W  lane i at bits [i*PAYLOAD_W +: PAYLOAD_W]
- in_ready  output  1  stage can accept a bundle this cycle
- kill  input  LANES  per-lane squash applied at capture (nop insertion)
- flush  input  1  synchronous bundle-wide discard
- out_valid  output  1  bundle available downstream
- out_lane_en  output  LANES  per-lane valid of output bundle
- out_payload  output  LANES*PAYLOAD_W  output bundle, same packing as input
- out_ready  input  1  downstream accepts bundle
- occupancy  output  2  bundles held: 0, 1 or 2
- stall_count  output  STALL_CNT_W  saturating count of backpressure cycles

Behaviour:
- Handshakes: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Reset asserted (reset=0), asynchronously:
  - state=EMPTY; main and skid payload/lane_en all zero.
  - out_valid=0, out_lane_en=0, out_payload=0, occupancy=0, stall_count=0, in_ready=1.
  - Inputs are ignored while reset is low. Reset mid-transfer drops all held bundles.
- Capture mask: cap_en = in_lane_en & ~kill. A lane with cap_en=0 is stored with payload zeroed.
- Empty bundle: if in_fire and cap_en==0, the bundle is accepted (in_ready honoured) but not stored, and state is unchanged. This is the bubble case.
- State EMPTY:
  - store-worthy in_fire -> FULL; main <= captured bundle.
- State FULL:
  - out_valid=1.
  - store-worthy in_fire & out_fire -> FULL; main <= new bundle.
  - store-worthy in_fire & ~out_fire -> SKID; skid <= new bundle.
  - no store & out_fire -> EMPTY.
- State SKID:
  - out_valid=1; in_ready=0.
  - out_fire -> FULL; main <= skid; skid cleared to zero.
- in_ready is a register equal to (next state != SKID); it has no combinational path from out_ready.
- Output timing:
  - out_* driven from main only; ordering is strictly FIFO.
  - Latency from in_fire (EMPTY) to out_valid is 1 cycle. Throughput is 1 bundle/cycle while out_ready=1.
- Zeroing:
  - out_payload lane i is all-zero whenever out_lane_en[i]=0.
  - out_payload and out_lane_en are all-zero whenever out_valid=0.
- Flush:
  - Highest priority below reset. Next state=EMPTY; main and skid zeroed; in_ready<=1.
  - A same-cycle in_fire is dropped, and a same-cycle out_fire is still a valid transfer of the old bundle.
- occupancy: EMPTY=0, FULL=1, SKID=2, registered with state.
- stall_count:
  - +1 each cycle with out_valid & ~out_ready; saturates at all-ones.
  - Cleared only by reset; flush does not clear it.
- Width rules: in_lane_en, kill and out_lane_en are bit-indexed by lane; no arithmetic on payload.

Test Plan:
- LANES=2, PAYLOAD_W=8, out_ready=1: in bundles A=(en=11, 0x11/0x22) then B=(en=11, 0x33/0x44) on consecutive cycles -> out_valid the cycle after each, payloads 0x11/0x22 then 0x33/0x44, occupancy stays 1, stall_count=0.
- Backpressure: out_ready=0, send A,B,C back-to-back -> A in main, B in skid, in_ready=0 after B, C held upstream, occupancy=2. Release out_ready -> outputs A,B,C in order; stall_count equals the number of held cycles.
- Kill: in_lane_en=11, kill=01, payload 0x55/0x66 -> out_lane_en=10, lane0 payload 0x00, lane1 0x66. kill=11 -> bundle accepted, out_valid stays 0.
- Flush in SKID with in_valid=1 -> next cycle occupancy=0, out_valid=0, out_payload=0, in_ready=1, flushed input never appears.
- Async reset pulse (reset=0 mid-cycle) while FULL -> outputs zero immediately without waiting for clk. After release, a new bundle propagates with 1-cycle latency.
- STALL_CNT_W=4, hold out_valid with out_ready=0 for 20 cycles -> stall_count saturates at 15.

Source files
------------

// File: rtl/issue_pipe_reg.sv
// rtl/issue_pipe_reg.sv - parametrised issue-bundle pipeline register with 2-entry skid buffer
//
// Holds one issue bundle of LANES lanes between decode/issue and register fetch.
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   in_valid     upstream bundle valid
//   in_lane_en   per-lane valid mask of the incoming bundle
//   in_payload   incoming bundle, lane i at [i*PAYLOAD_W +: PAYLOAD_W]
//   in_ready     registered; stage can accept a bundle this cycle
//   kill         per-lane squash applied at capture
//   flush        synchronous bundle-wide discard
//   out_valid    bundle available downstream
//   out_lane_en  per-lane valid of the output bundle
//   out_payload  output bundle, same packing as in_payload
//   out_ready    downstream accepts the bundle
//   occupancy    bundles held (0, 1 or 2)
//   stall_count  saturating count of out_valid & ~out_ready cycles
module issue_pipe_reg #(
    parameter int LANES       = 2,
    parameter int PAYLOAD_W   = 480,
    parameter int STALL_CNT_W = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic [LANES-1:0]             in_lane_en,
    input  logic [LANES*PAYLOAD_W-1:0]   in_payload,
    output logic                         in_ready,
    input  logic [LANES-1:0]             kill,
    input  logic                         flush,
    output logic                         out_valid,
    output logic [LANES-1:0]             out_lane_en,
    output logic [LANES*PAYLOAD_W-1:0]   out_payload,
    input  logic                         out_ready,
    output logic [1:0]                   occupancy,
    output logic [STALL_CNT_W-1:0]       stall_count
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t                        state, state_n;
    logic [LANES-1:0]              main_en, main_en_n;
    logic [LANES*PAYLOAD_W-1:0]    main_payload, main_payload_n;
    logic [LANES-1:0]              skid_en, skid_en_n;
    logic [LANES*PAYLOAD_W-1:0]    skid_payload, skid_payload_n;
    logic                          in_ready_q, in_ready_n;
    logic [STALL_CNT_W-1:0]        stall_q, stall_n;

    logic [LANES-1:0]              cap_en;
    logic [LANES*PAYLOAD_W-1:0]    cap_payload;
    logic                          in_fire;
    logic                          out_fire;
    logic                          store;

    // Killed or disabled lanes are stored as zero so downstream sees clean nops.
    always_comb begin
        cap_en      = in_lane_en & ~kill;
        cap_payload = '0;
        for (int i = 0; i < LANES; i++) begin
            if (cap_en[i]) begin
                cap_payload[i*PAYLOAD_W +: PAYLOAD_W] = in_payload[i*PAYLOAD_W +: PAYLOAD_W];
            end
        end
    end

    assign out_valid = (state != ST_EMPTY);
    assign in_fire   = in_valid & in_ready_q;
    assign out_fire  = out_valid & out_ready;
    // A bundle with no surviving lane is a bubble: accepted but never stored.
    assign store     = in_fire & (|cap_en);

    always_comb begin
        state_n        = state;
        main_en_n      = main_en;
        main_payload_n = main_payload;
        skid_en_n      = skid_en;
        skid_payload_n = skid_payload;

        unique case (state)
            ST_EMPTY: begin
                if (store) begin
                    state_n        = ST_FULL;
                    main_en_n      = cap_en;
                    main_payload_n = cap_payload;
                end
            end
            ST_FULL: begin
                if (store && out_fire) begin
                    main_en_n      = cap_en;
                    main_payload_n = cap_payload;
                end else if (store) begin
                    state_n        = ST_SKID;
                    skid_en_n      = cap_en;
                    skid_payload_n = cap_payload;
                end else if (out_fire) begin
                    state_n        = ST_EMPTY;
                    main_en_n      = '0;
                    main_payload_n = '0;
                end
            end
            ST_SKID: begin
                if (out_fire) begin
                    state_n        = ST_FULL;
                    main_en_n      = skid_en;
                    main_payload_n = skid_payload;
                    skid_en_n      = '0;
                    skid_payload_n = '0;
                end
            end
            default: begin
                state_n        = ST_EMPTY;
                main_en_n      = '0;
                main_payload_n = '0;
                skid_en_n      = '0;
                skid_payload_n = '0;
            end
        endcase

        // Flush overrides everything; a same-cycle out_fire already moved the old bundle.
        if (flush) begin
            state_n        = ST_EMPTY;
            main_en_n      = '0;
            main_payload_n = '0;
            skid_en_n      = '0;
            skid_payload_n = '0;
        end

        // Registered ready: no combinational path from out_ready to in_ready.
        in_ready_n = (state_n != ST_SKID);

        stall_n = stall_q;
        if (out_valid && !out_ready && !(&stall_q)) begin
            stall_n = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_EMPTY;
            main_en      <= '0;
            main_payload <= '0;
            skid_en      <= '0;
            skid_payload <= '0;
            in_ready_q   <= 1'b1;
            stall_q      <= '0;
        end else begin
            state        <= state_n;
            main_en      <= main_en_n;
            main_payload <= main_payload_n;
            skid_en      <= skid_en_n;
            skid_payload <= skid_payload_n;
            in_ready_q   <= in_ready_n;
            stall_q      <= stall_n;
        end
    end

    // Main is already zeroed when empty; the gating keeps the zero guarantee explicit.
    assign out_lane_en = out_valid ? main_en : '0;
    assign out_payload = out_valid ? main_payload : '0;
    assign in_ready    = in_ready_q;
    assign stall_count = stall_q;

    always_comb begin
        unique case (state)
            ST_FULL: occupancy = 2'd1;
            ST_SKID: occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

endmodule

// File: tb/tb_issue_pipe_reg.sv
// tb/tb_issue_pipe_reg.sv - randomized self-checking bench for issue_pipe_reg against a queue model
module tb_issue_pipe_reg;

    localparam int LANES = 2;
    localparam int PW    = 8;
    localparam int SW    = 4;

    logic                  clk;
    logic                  reset;
    logic                  in_valid;
    logic [LANES-1:0]      in_lane_en;
    logic [LANES*PW-1:0]   in_payload;
    logic                  in_ready;
    logic [LANES-1:0]      kill;
    logic                  flush;
    logic                  out_valid;
    logic [LANES-1:0]      out_lane_en;
    logic [LANES*PW-1:0]   out_payload;
    logic                  out_ready;
    logic [1:0]            occupancy;
    logic [SW-1:0]         stall_count;

    issue_pipe_reg #(.LANES(LANES), .PAYLOAD_W(PW), .STALL_CNT_W(SW)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_lane_en  (in_lane_en),
        .in_payload  (in_payload),
        .in_ready    (in_ready),
        .kill        (kill),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_lane_en (out_lane_en),
        .out_payload (out_payload),
        .out_ready   (out_ready),
        .occupancy   (occupancy),
        .stall_count (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: the held bundles as a FIFO of {lane_en, payload}, plus a stall counter.
    logic [LANES+LANES*PW-1:0] q[$];
    int                        exp_stall = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [LANES-1:0]    e_en;
        logic [LANES*PW-1:0] e_pl;
        e_en = '0;
        e_pl = '0;
        if (q.size() > 0) begin
            e_en = q[0][LANES+LANES*PW-1 -: LANES];
            e_pl = q[0][LANES*PW-1:0];
        end
        check("out_valid",   64'(out_valid),   64'(q.size() > 0));
        check("out_lane_en", 64'(out_lane_en), 64'(e_en));
        check("out_payload", 64'(out_payload), 64'(e_pl));
        check("in_ready",    64'(in_ready),    64'(q.size() < 2));
        check("occupancy",   64'(occupancy),   64'(q.size()));
        check("stall_count", 64'(stall_count), 64'(exp_stall));
    endtask

    // One cycle: check current outputs at negedge, drive inputs, advance the model.
    task automatic step(input logic v, input logic [LANES-1:0] en, input logic [LANES*PW-1:0] pl,
                        input logic [LANES-1:0] k, input logic fl, input logic ordy);
        logic [LANES-1:0]    cap;
        logic [LANES*PW-1:0] cpl;
        logic                ofire;
        logic                ifire;
        @(negedge clk);
        check_outputs();
        in_valid   = v;
        in_lane_en = en;
        in_payload = pl;
        kill       = k;
        flush      = fl;
        out_ready  = ordy;

        cap = en & ~k;
        cpl = '0;
        for (int i = 0; i < LANES; i++) begin
            if (cap[i]) cpl[i*PW +: PW] = pl[i*PW +: PW];
        end
        ofire = (q.size() > 0) && ordy;
        ifire = v && (q.size() < 2);
        if ((q.size() > 0) && !ordy && exp_stall < (1 << SW) - 1) exp_stall++;
        if (fl) begin
            q.delete();
        end else begin
            if (ofire) void'(q.pop_front());
            if (ifire && cap != '0) q.push_back({cap, cpl});
        end
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, '0, '0, '0, 1'b0, ordy);
    endtask

    initial begin
        reset      = 1'b0;
        in_valid   = 1'b0;
        in_lane_en = '0;
        in_payload = '0;
        kill       = '0;
        flush      = 1'b0;
        out_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        reset = 1'b1;

        // Back-to-back A, B with out_ready high.
        step(1'b1, 2'b11, 16'h2211, 2'b00, 1'b0, 1'b1);
        step(1'b1, 2'b11, 16'h4433, 2'b00, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Backpressure: A, B, C with out_ready low, then release.
        step(1'b1, 2'b11, 16'hA1A0, 2'b00, 1'b0, 1'b0);
        step(1'b1, 2'b11, 16'hB1B0, 2'b00, 1'b0, 1'b0);
        step(1'b1, 2'b11, 16'hC1C0, 2'b00, 1'b0, 1'b0);
        step(1'b1, 2'b11, 16'hC1C0, 2'b00, 1'b0, 1'b0);
        check("skid_occ", 64'(occupancy), 64'd2);
        step(1'b1, 2'b11, 16'hC1C0, 2'b00, 1'b0, 1'b1);
        step(1'b1, 2'b11, 16'hC1C0, 2'b00, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        // Kill lane 0, then kill both lanes (bubble).
        step(1'b1, 2'b11, 16'h6655, 2'b01, 1'b0, 1'b1);
        step(1'b1, 2'b11, 16'h7777, 2'b11, 1'b0, 1'b1);
        idle(1'b1);

        // Flush while in SKID with in_valid high.
        step(1'b1, 2'b11, 16'h0102, 2'b00, 1'b0, 1'b0);
        step(1'b1, 2'b11, 16'h0304, 2'b00, 1'b0, 1'b0);
        step(1'b1, 2'b11, 16'h0506, 2'b00, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Saturation: hold one bundle with out_ready low for 20 cycles.
        step(1'b1, 2'b10, 16'h9900, 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) idle(1'b0);
        @(negedge clk);
        check("stall_sat", 64'(stall_count), 64'd15);

        // Asynchronous reset mid-cycle while FULL.
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        #2 reset = 1'b0;
        #1;
        q.delete();
        exp_stall = 0;
        check_outputs();
        @(negedge clk);
        reset = 1'b1;
        step(1'b1, 2'b01, 16'h00EE, 2'b00, 1'b0, 1'b1);
        idle(1'b1);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 9) < 7),
                 LANES'($urandom),
                 (LANES*PW)'($urandom),
                 ($urandom_range(0, 3) == 0) ? LANES'($urandom) : '0,
                 ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 9) < 6));
        end
        idle(1'b1);
        idle(1'b1);
        @(negedge clk);
        check_outputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
